// File: rtl/ev19_soc_led_pio_if.sv
// Avalon-MM slave bus of the LED PIO: 3-bit register select, 32-bit write and read data.
// No waitrequest: the slave accepts every access and answers reads one cycle later.
interface ev19_soc_led_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/ev19_soc_led_pio.sv
// LED/actuator PIO with set/clear aliases; timed pulse FSM only when EV19_LED_PIO_PULSE_EN is defined.
// Writes land next cycle, reads return one cycle after the address; no backpressure (never stalls).
module ev19_soc_led_pio #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic               clk,
  input  logic               reset,
  ev19_soc_led_pio_if.slave  bus,
  output logic [WIDTH-1:0]   out_port
);
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_LEN  = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] pulse_vis;
  logic             busy;
  logic [15:0]      pulse_len_rd;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wr_bits      = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= RESET_VALUE[WIDTH-1:0];
    end else if (wr_en) begin
      case (bus.address)
        ADDR_DATA: data_reg <= wr_bits;
        ADDR_SET:  data_reg <= data_reg | wr_bits;
        ADDR_CLR:  data_reg <= data_reg & ~wr_bits;
        default:   ;
      endcase
    end
  end

`ifdef EV19_LED_PIO_PULSE_EN
  typedef enum logic {IDLE, PULSE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pulse_bits;
  logic [15:0]      count;
  logic [15:0]      pulse_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_len <= '0;
    end else if (wr_en && bus.address == ADDR_LEN) begin
      pulse_len <= bus.writedata[15:0];
    end
  end

  // pulse_bits is cleared on every return to IDLE so the output OR needs no state gating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pulse_bits <= '0;
      count      <= '0;
    end else if (wr_en && bus.address == ADDR_MASK) begin
      if (wr_bits != '0 && pulse_len != 16'd0) begin
        state      <= PULSE;
        pulse_bits <= wr_bits;
        count      <= pulse_len;
      end else begin
        state      <= IDLE;
        pulse_bits <= '0;
        count      <= '0;
      end
    end else if (state == PULSE) begin
      if (count == 16'd1) begin
        state      <= IDLE;
        pulse_bits <= '0;
        count      <= '0;
      end else begin
        count <= count - 16'd1;
      end
    end
  end

  assign pulse_vis    = pulse_bits;
  assign busy         = (state == PULSE);
  assign pulse_len_rd = pulse_len;
`else
  assign pulse_vis    = '0;
  assign busy         = 1'b0;
  assign pulse_len_rd = '0;
`endif

  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA: rd_next[WIDTH-1:0] = data_reg;
      ADDR_MASK: begin
        rd_next[WIDTH-1:0] = pulse_vis;
        rd_next[31]        = busy;
      end
      ADDR_LEN:  rd_next[15:0] = pulse_len_rd;
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

  // Pure OR of flops: async reset clears both terms together, so no glitch to pulse bits.
  assign out_port = data_reg | pulse_vis;
endmodule

// File: tb/tb_ev19_soc_led_pio.sv
// Randomized plus directed bench for ev19_soc_led_pio; a reference model pushes expected
// readdata/out_port per clock edge and a monitor pops and compares after each edge.
module tb_ev19_soc_led_pio;
  localparam int          WIDTH  = 8;
  localparam logic [31:0] RV     = 32'h0000_01C3;
  localparam logic [7:0]  RV_OUT = 8'hC3;
`ifdef EV19_LED_PIO_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]      rd;
    logic [WIDTH-1:0] outp;
    logic [15:0]      id;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] out_port;

  ev19_soc_led_pio_if bus ();

  ev19_soc_led_pio #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state: pulse active after edge j iff j < m_end.
  logic [7:0]  m_data;
  logic [15:0] m_len;
  logic [7:0]  m_bits;
  int          m_end;
  int          edge_no;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (op %0d): got %h expected %h", name, id, act, exp);
  endtask

  task automatic model_reset();
    m_data = RV_OUT;
    m_len  = 16'd0;
    m_bits = 8'h00;
    m_end  = 0;
  endtask

  task automatic do_op(input logic [2:0] a, input bit wr, input logic [31:0] wd);
    exp_t       e;
    logic       act_prev;
    logic [7:0] wb;
    wb = wd[7:0];
    bus.address   = a;
    bus.writedata = wd;
    if (wr) begin
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
    end else if ($urandom_range(0, 1) == 0) begin
      bus.chipselect = 1'b0;
      bus.write_n    = 1'($urandom_range(0, 1));
    end else begin
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
    end
    act_prev = (edge_no - 1) < m_end;
    e.rd = 32'h0;
    case (a)
      3'd0: e.rd = {24'h0, m_data};
      3'd2: if (PULSE_EN) e.rd = {act_prev, 23'h0, act_prev ? m_bits : 8'h00};
      3'd3: if (PULSE_EN) e.rd = {16'h0, m_len};
      default: ;
    endcase
    if (wr) begin
      case (a)
        3'd0: m_data = wb;
        3'd4: m_data = m_data | wb;
        3'd5: m_data = m_data & ~wb;
        3'd3: if (PULSE_EN) m_len = wd[15:0];
        3'd2: if (PULSE_EN) begin
          if (wb != 8'h00 && m_len != 16'd0) begin
            m_bits = wb;
            m_end  = edge_no + int'(m_len);
          end else begin
            m_end = edge_no;
          end
        end
        default: ;
      endcase
    end
    e.outp = m_data | ((edge_no < m_end) ? m_bits : 8'h00);
    e.id   = 16'(edge_no);
    sb.push_back(e);
    edge_no++;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_readdata", int'(e.id), bus.readdata, e.rd);
        check("sb_out_port", int'(e.id), 32'(out_port), 32'(e.outp));
      end
    end
  end

  initial begin : stim
    logic [2:0]  a;
    logic [31:0] wd;
    bit          wr;
    reset          = 1'b1;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    edge_no        = 1;
    model_reset();
    #2;
    check("reset_out", 0, 32'(out_port), 32'(RV_OUT));
    check("reset_rd", 0, bus.readdata, 32'h0);
    repeat (3) @(negedge clk);
    check("reset_hold_out", 0, 32'(out_port), 32'(RV_OUT));
    reset = 1'b0;

    do_op(3'd0, 1'b1, 32'hFFFF_FF5A);
    check("wr_data_out", 1, 32'(out_port), 32'h5A);
    do_op(3'd0, 1'b0, 32'h0);
    check("rd_data", 2, bus.readdata, 32'h0000_005A);

    do_op(3'd0, 1'b1, 32'h0F);
    do_op(3'd4, 1'b1, 32'h30);
    check("outset", 4, 32'(out_port), 32'h3F);
    do_op(3'd5, 1'b1, 32'h03);
    check("outclear", 5, 32'(out_port), 32'h3C);

    do_op(3'd0, 1'b1, 32'h00);
    do_op(3'd3, 1'b1, 32'd5);
    do_op(3'd2, 1'b1, 32'h81);
    check("pulse_start", 8, 32'(out_port), PULSE_EN ? 32'h81 : 32'h00);
    for (int i = 0; i < 7; i++) begin
      do_op(3'd2, 1'b0, 32'h0);
      check("pulse_len5_out", 9 + i, 32'(out_port), (PULSE_EN && i < 4) ? 32'h81 : 32'h00);
      check("pulse_len5_rd", 9 + i, bus.readdata, (PULSE_EN && i < 5) ? 32'h8000_0081 : 32'h0);
    end

    do_op(3'd3, 1'b1, 32'd10);
    do_op(3'd2, 1'b1, 32'h01);
    repeat (3) do_op(3'd0, 1'b0, 32'h0);
    do_op(3'd2, 1'b1, 32'h02);
    check("retrigger", 0, 32'(out_port), PULSE_EN ? 32'h02 : 32'h00);
    for (int i = 0; i < 10; i++) begin
      do_op(3'd1, 1'b0, 32'h0);
      check("retrigger_len", i, 32'(out_port), (PULSE_EN && i < 9) ? 32'h02 : 32'h00);
    end
    do_op(3'd2, 1'b1, 32'h04);
    do_op(3'd2, 1'b1, 32'h00);
    check("cancel_out", 0, 32'(out_port), 32'h00);
    do_op(3'd2, 1'b0, 32'h0);
    check("cancel_rd", 0, bus.readdata, 32'h0);

    do_op(3'd3, 1'b1, 32'd0);
    do_op(3'd2, 1'b1, 32'hFF);
    check("len0_out", 0, 32'(out_port), 32'h00);
    do_op(3'd2, 1'b0, 32'h0);
    check("len0_busy", 0, bus.readdata, 32'h0);

    for (int i = 0; i < 600; i++) begin
      a  = 3'($urandom_range(0, 7));
      wr = ($urandom_range(0, 2) != 0);
      wd = $urandom;
      if (a == 3'd3) wd = (wd & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
      if (a == 3'd2 && $urandom_range(0, 4) == 0) wd = 32'h0;
      do_op(a, wr, wd);
    end

    do_op(3'd0, 1'b1, 32'h00);
    do_op(3'd3, 1'b1, 32'd8);
    do_op(3'd2, 1'b1, 32'h3C);
    do_op(3'd0, 1'b0, 32'h0);
    do_op(3'd0, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_pulse_out", 0, 32'(out_port), 32'(RV_OUT));
    check("reset_mid_pulse_rd", 0, bus.readdata, 32'h0);
    @(posedge clk);
    #1;
    check("reset_held_out", 0, 32'(out_port), 32'(RV_OUT));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_op(3'd0, 1'b1, 32'h5A);
    check("first_write", 0, 32'(out_port), 32'h5A);
    do_op(3'd2, 1'b1, 32'hFF);
    check("mask_no_len_out", 0, 32'(out_port), 32'h5A);
    do_op(3'd2, 1'b0, 32'h0);
    check("mask_no_len_rd", 0, bus.readdata, 32'h0);

    bus.chipselect = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 0, 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ev19_soc_led_pio.md
EV19_SOC_LED_PIO -- requirements
Module: ev19_soc_led_pio

Interface
REQ-001 Parameter WIDTH, default 8: number of output bits driven on out_port, range 1..16.
REQ-002 Parameter RESET_VALUE, default 0: value loaded into the data register at reset; only bits [WIDTH-1:0] are used.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 address  input  3: Avalon-MM slave register select.
REQ-006 chipselect  input  1: slave selected this cycle.
REQ-007 write_n  input  1: active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-008 writedata  input  32: write data.
REQ-009 readdata  output  32: registered read data.
REQ-010 out_port  output  WIDTH: driven output pins (LEDs / actuators).

Function
REQ-011 Register map: 0 data (R/W); 1 reserved (reads 0, writes ignored); 2 pulse mask/status (R/W); 3 pulse length (R/W, 16 bits); 4 outset (W, reads 0); 5 outclear (W, reads 0); 6-7 read 0, writes ignored.
REQ-012 Write to 0: data_reg <= writedata[WIDTH-1:0], visible on out_port the next cycle.
REQ-013 Write to 4: data_reg <= data_reg | writedata[WIDTH-1:0]; write to 5: data_reg <= data_reg & ~writedata[WIDTH-1:0].
REQ-014 Write to 3: pulse_len <= writedata[15:0]; does not affect a pulse already running.
REQ-015 Pulse FSM states IDLE and PULSE; counter is 16 bits.
REQ-016 IDLE -> PULSE on a write to 2 with writedata[WIDTH-1:0] != 0 and pulse_len != 0: pulse_bits <= writedata[WIDTH-1:0], count <= pulse_len.
REQ-017 In PULSE, count decrements by 1 each cycle; PULSE -> IDLE when count = 1, so pulse bits are high for exactly pulse_len cycles, starting the cycle after the write.
REQ-018 A write to 2 during PULSE with a nonzero mask retriggers: it replaces pulse_bits, reloads count from pulse_len, and stays in PULSE.
REQ-019 A write to 2 with mask 0 goes to IDLE immediately (cancel), as does any write to 2 while pulse_len = 0.
REQ-020 out_port = data_reg | (PULSE ? pulse_bits : 0); the output is driven from registers only, with no combinational path from the bus.
REQ-021 Data, outset and outclear writes during PULSE are independent of the pulse; after expiry, out_port reverts to data_reg.
REQ-022 readdata is updated every clk cycle, independent of chipselect, with the addressed value zero-extended to 32 bits; read latency is 1 cycle.
REQ-023 Read of 0 returns data_reg; read of 2 returns {busy at bit 31, zeros, pulse_bits when in PULSE else 0}; read of 3 returns {16'b0, pulse_len}.

Reset
REQ-024 While reset=1: data_reg=RESET_VALUE, pulse_len=0, state=IDLE, pulse_bits=0, count=0, readdata=0, out_port=RESET_VALUE.
REQ-025 Reset asserted mid-pulse aborts the pulse immediately and asynchronously; out_port shows RESET_VALUE with no glitch back to the pulse bits.
REQ-026 The first write is accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro EV19_LED_PIO_PULSE_EN defined: the pulse FSM, pulse_len and addresses 2/3 are implemented as specified above.
REQ-028 Macro EV19_LED_PIO_PULSE_EN undefined: no pulse logic is synthesized; addresses 2/3 read 0 and writes to them are ignored; out_port = data_reg.

Verification
REQ-029 Reset, then write 0x5A to addr 0 -> out_port=0x5A the next cycle; a read of addr 0 returns 0x0000005A one cycle after address is presented.
REQ-030 data=0x0F, write 0x30 to addr 4, then 0x03 to addr 5 -> out_port=0x3F, then 0x3C.
REQ-031 pulse_len=5, data=0x00, write 0x81 to addr 2 -> out_port=0x81 for exactly 5 cycles, then 0x00; a read of addr 2 during the pulse returns 0x80000081, and after it returns 0.
REQ-032 pulse_len=10, write 0x01 to addr 2, at cycle 4 write 0x02 to addr 2 -> bit 0 drops, bit 1 is high for 10 cycles from the retrigger; writing mask 0 instead cancels all pulse bits the next cycle.
REQ-033 pulse_len=0, write 0xFF to addr 2 -> no pulse and busy=0; reset asserted at cycle 3 of a pulse_len=8 pulse -> out_port=RESET_VALUE immediately and state=IDLE.
REQ-034 Build without EV19_LED_PIO_PULSE_EN: write 0xFF to addr 2 -> out_port unchanged, and a read of addr 2 returns 0.
